// File: rtl/myip_servo_multi.sv
// myip_servo_multi: AXI4-Lite slave driving N_CH hobby-servo PWM outputs from a
// shared, double-buffered frame period. Widths and period written over the bus
// are shadowed into the PWM core only at frame boundaries.
// Optional feature: define SERVO_RAMP_EN to slew each effective width toward
// its target by at most STEP ticks per frame; without it STEP reads as 0.
module myip_servo_multi #(
  parameter int N_CH                 = 4,
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 6,
  parameter int CLK_HZ               = 100_000_000,
  parameter int TICK_HZ              = 1_000_000,
  parameter int CNT_W                = 16
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [N_CH-1:0]                   servo_out,
  output logic                              frame_start
);

  localparam int IDX_W = C_S00_AXI_ADDR_WIDTH - 2;
  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PRESC_MAX  = PW'(DIV - 1);
  localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(20000);
  localparam logic [CNT_W-1:0] WIDTH_RST  = CNT_W'(1500);
  localparam logic [31:0]      CTRL_MASK  = 32'h1 | (((32'h1 << N_CH) - 32'h1) << 8);

  logic             aw_ready, b_valid, ar_ready, r_valid;
  logic [31:0]      r_data, rd_word, ctrl;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             wr_fire, rd_fire;
  logic [CNT_W-1:0] period_reg, period_sh, period_merged, cnt;
  logic [CNT_W-1:0] width_tgt [N_CH];
  logic [CNT_W-1:0] width_sh  [N_CH];
  logic [PW-1:0]    presc;
  logic             gen, run, tick, boundary;
  logic [N_CH-1:0]  ch_en;
`ifdef SERVO_RAMP_EN
  logic [CNT_W-1:0] step_reg;
`endif

  // Byte-lane merge of a write into the current 32-bit register image.
  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

`ifdef SERVO_RAMP_EN
  // Move cur toward tgt by at most step; a zero step jumps straight to tgt.
  function automatic logic [CNT_W-1:0] ramp_step(input logic [CNT_W-1:0] cur,
                                                 input logic [CNT_W-1:0] tgt,
                                                 input logic [CNT_W-1:0] step);
    logic [CNT_W-1:0] res;
    res = tgt;
    if (step != '0) begin
      if (tgt > cur && (tgt - cur) > step)      res = cur + step;
      else if (cur > tgt && (cur - tgt) > step) res = cur - step;
    end
    return res;
  endfunction
`endif

  assign wr_idx        = s00_axi_awaddr[C_S00_AXI_ADDR_WIDTH-1:2];
  assign rd_idx        = s00_axi_araddr[C_S00_AXI_ADDR_WIDTH-1:2];
  assign wr_fire       = aw_ready & s00_axi_awvalid & s00_axi_wvalid;
  assign rd_fire       = ar_ready & s00_axi_arvalid;
  assign period_merged = CNT_W'(apply_strb(32'(period_reg), s00_axi_wdata, s00_axi_wstrb));

  assign s00_axi_awready = aw_ready;
  assign s00_axi_wready  = aw_ready;
  assign s00_axi_bvalid  = b_valid;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = ar_ready;
  assign s00_axi_rvalid  = r_valid;
  assign s00_axi_rdata   = r_data;
  assign s00_axi_rresp   = 2'b00;

  // Write channel: AW and W are accepted together, then the response is held until bready.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_ready <= 1'b0;
      b_valid  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      aw_ready <= s00_axi_awvalid & s00_axi_wvalid & ~b_valid & ~aw_ready;
      if (wr_fire)             b_valid <= 1'b1;
      else if (s00_axi_bready) b_valid <= 1'b0;
    end
  end

  // Register file updates on the accepting write edge.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      ctrl       <= '0;
      period_reg <= PERIOD_RST;
`ifdef SERVO_RAMP_EN
      step_reg   <= '0;
`endif
      // NOTE: the width array is only N_CH words with defined reset values, so it is reset like any flop.
      for (int k = 0; k < N_CH; k++) width_tgt[k] <= WIDTH_RST;
    end else if (wr_fire) begin
      if (int'(wr_idx) == 0) ctrl <= apply_strb(ctrl, s00_axi_wdata, s00_axi_wstrb) & CTRL_MASK;
      if (int'(wr_idx) == 1 && period_merged != '0) period_reg <= period_merged;
`ifdef SERVO_RAMP_EN
      if (int'(wr_idx) == 3)
        step_reg <= CNT_W'(apply_strb(32'(step_reg), s00_axi_wdata, s00_axi_wstrb));
`endif
      for (int k = 0; k < N_CH; k++)
        if (int'(wr_idx) == 4 + k)
          width_tgt[k] <= CNT_W'(apply_strb(32'(width_tgt[k]), s00_axi_wdata, s00_axi_wstrb));
    end
  end

  // Read mux; unmapped offsets return zero.
  always_comb begin
    // NOTE: default first so no path through the case leaves rd_word unassigned (no latch).
    rd_word = '0;
    case (int'(rd_idx))
      0: rd_word = ctrl;
      1: rd_word = 32'(period_reg);
      2: begin
        rd_word     = 32'(cnt);
        rd_word[31] = ctrl[0];
      end
`ifdef SERVO_RAMP_EN
      3: rd_word = 32'(step_reg);
`endif
      default: begin
        for (int k = 0; k < N_CH; k++)
          if (int'(rd_idx) == 4 + k) rd_word = 32'(width_tgt[k]);
      end
    endcase
  end

  // Read channel: capture data on the accepting edge, hold rvalid until rready.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      ar_ready <= s00_axi_arvalid & ~r_valid & ~ar_ready;
      if (rd_fire) begin
        r_valid <= 1'b1;
        r_data  <= rd_word;
      end else if (s00_axi_rready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign gen      = ctrl[0];
  assign ch_en    = ctrl[8 +: N_CH];
  assign tick     = gen & (presc == PRESC_MAX);
  // run is low until the first tick after enable, which is therefore a boundary.
  assign boundary = tick & (~run | (cnt >= period_sh - CNT_W'(1)));

  // Prescaler, tick counter and shadow loads at each frame boundary.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      presc       <= '0;
      cnt         <= '0;
      run         <= 1'b0;
      frame_start <= 1'b0;
      period_sh   <= PERIOD_RST;
      for (int k = 0; k < N_CH; k++) width_sh[k] <= WIDTH_RST;
    end else if (!gen) begin
      presc       <= '0;
      cnt         <= '0;
      run         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
      presc       <= tick ? '0 : presc + PW'(1);
      if (boundary) begin
        cnt       <= '0;
        run       <= 1'b1;
        period_sh <= period_reg;
        for (int k = 0; k < N_CH; k++) begin
`ifdef SERVO_RAMP_EN
          width_sh[k] <= ramp_step(width_sh[k], width_tgt[k], step_reg);
`else
          width_sh[k] <= width_tgt[k];
`endif
        end
      end else if (tick) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Registered PWM compare; disabled channels and a stopped core drive low.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) servo_out <= '0;
    else
      for (int k = 0; k < N_CH; k++)
        servo_out[k] <= gen & run & ch_en[k] & (cnt < width_sh[k]);
  end

  logic unused_bits;
  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

endmodule

// File: tb/tb_myip_servo_multi.sv
// tb_myip_servo_multi: randomized self-checking bench for myip_servo_multi.
// A frame monitor measures each frame's length and per-channel high time, which
// are compared against a register-level model of the PWM rules.
module tb_myip_servo_multi;
  localparam int N_CH = 4;
  localparam int DIV  = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [N_CH-1:0] servo_out;
  logic        frame_start;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  myip_servo_multi #(.N_CH(N_CH), .C_S00_AXI_DATA_WIDTH(32), .C_S00_AXI_ADDR_WIDTH(6),
                     .CLK_HZ(100_000_000), .TICK_HZ(1_000_000), .CNT_W(16)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .servo_out(servo_out), .frame_start(frame_start)
  );

  // Frame monitor: a frame spans the samples after one frame_start up to and
  // including the next one (the registered output lags the counter by a clock).
  int frame_cnt = 0;
  int cur_len = 0;
  int last_len = 0;
  int cur_hi [N_CH];
  int last_hi [N_CH];
  always @(negedge clk) begin
    if (frame_start === 1'b1) begin
      last_len  <= cur_len + 1;
      cur_len   <= 0;
      frame_cnt <= frame_cnt + 1;
      for (int k = 0; k < N_CH; k++) begin
        last_hi[k] <= cur_hi[k] + int'(servo_out[k]);
        cur_hi[k]  <= 0;
      end
    end else begin
      cur_len <= cur_len + 1;
      for (int k = 0; k < N_CH; k++) cur_hi[k] <= cur_hi[k] + int'(servo_out[k]);
    end
  end

  // Register model, indexed by word offset.
  logic [31:0] m_reg [16];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 32'h0;
    m_reg[1] = 32'd20000;
    for (int k = 0; k < N_CH; k++) m_reg[4+k] = 32'd1500;
  endtask

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = m_reg[idx];
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    if (idx == 0) m_reg[0] = v & 32'h0000_0F01;
    if (idx == 1 && (v & 32'hFFFF) != 0) m_reg[1] = v & 32'hFFFF;
`ifdef SERVO_RAMP_EN
    if (idx == 3) m_reg[3] = v & 32'hFFFF;
`endif
    if (idx >= 4 && idx < 4 + N_CH) m_reg[idx] = v & 32'hFFFF;
  endtask

  // Expected high clocks per steady frame for channel k (width loaded directly).
  function automatic int exp_hi(input int k);
    int w, p;
    w = int'(m_reg[4+k]);
    p = int'(m_reg[1]);
    if (!(m_reg[0][0] && m_reg[0][8+k])) return 0;
    return ((w < p) ? w : p) * DIV;
  endfunction

`ifdef SERVO_RAMP_EN
  function automatic int ramp_next(input int cur, input int tgt, input int step);
    int d;
    d = tgt - cur;
    if (step == 0 || ((d < 0) ? -d : d) <= step) return tgt;
    return (d > 0) ? cur + step : cur - step;
  endfunction
`endif

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(posedge clk); #1;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (awready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    while (bvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n_cmp++;
    if (n >= 50 || bresp !== 2'b00) begin
      n_bad++;
      $display("FAIL axi_write 0x%02h: bresp=%0d timeout_cycles=%0d, required bresp=0 within 50", addr, bresp, n);
    end
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data);
    int n;
    @(posedge clk); #1;
    araddr = addr; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (arready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    @(negedge clk);
    while (rvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    data = rdata;
    n_cmp++;
    if (n >= 50 || rresp !== 2'b00) begin
      n_bad++;
      $display("FAIL axi_read 0x%02h: rresp=%0d timeout_cycles=%0d, required rresp=0 within 50", addr, rresp, n);
    end
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic wr(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb = 4'hF);
    axi_write(addr, data, strb);
    model_write(int'(addr[5:2]), data, strb);
  endtask

  task automatic wait_frames(input int n);
    int target, budget;
    target = frame_cnt + n;
    budget = 0;
    while (frame_cnt < target && budget < n * 12000) begin @(negedge clk); budget++; end
    if (frame_cnt < target) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_frames: saw %0d frames, required %0d", frame_cnt - target + n, n);
    end
  endtask

  task automatic check_frame(input string name);
    n_cmp++;
    if (last_len !== int'(m_reg[1]) * DIV) begin
      n_bad++;
      $display("FAIL %s frame_len: got %0d, required %0d", name, last_len, int'(m_reg[1]) * DIV);
    end
    for (int k = 0; k < N_CH; k++) begin
      n_cmp++;
      if (last_hi[k] !== exp_hi(k)) begin
        n_bad++;
        $display("FAIL %s ch%0d high: got %0d, required %0d", name, k, last_hi[k], exp_hi(k));
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int idx_list [9] = '{0, 1, 3, 4, 5, 6, 7, 8, 14};
    model_reset();
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata, servo_out, frame_start} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got nonzero (rdata=%h servo=%b), required all 0", rdata, servo_out);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (300) @(negedge clk);
    n_cmp++;
    if (frame_cnt !== 0 || servo_out !== '0) begin
      n_bad++;
      $display("FAIL reset_idle: frames=%0d servo=%b, required 0 and 0000", frame_cnt, servo_out);
    end
`ifndef SERVO_RAMP_EN
    wr(6'h0C, 32'd7);
`endif
    foreach (idx_list[i]) begin
      axi_read(6'(idx_list[i] * 4), d);
      n_cmp++;
      if (d !== m_reg[idx_list[i]]) begin
        n_bad++;
        $display("FAIL reset_read 0x%02h: got %0d, required %0d", idx_list[i] * 4, d, m_reg[idx_list[i]]);
      end
    end
    axi_read(6'h08, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_status: got %h, required 0", d);
    end
  endtask

  task automatic test_basic();
    wr(6'h04, 32'd100);
    wr(6'h10, 32'd25);
    wr(6'h00, 32'h101);
    wait_frames(2);
    check_frame("basic");
  endtask

  task automatic test_midframe();
    int old_hi;
    old_hi = exp_hi(0);
    repeat (10 * DIV) @(negedge clk);
    wr(6'h10, 32'd60);
    wait_frames(1);
    n_cmp++;
    if (last_hi[0] !== old_hi) begin
      n_bad++;
      $display("FAIL midframe_current: got %0d, required %0d", last_hi[0], old_hi);
    end
    wait_frames(1);
    check_frame("midframe_next");
  endtask

  task automatic test_edge_widths();
    logic [31:0] d;
    wr(6'h04, 32'd40);
    wr(6'h14, 32'd0);
    wr(6'h18, 32'd200);
    wr(6'h1C, 32'hFFFF_FF10, 4'b0001);
    wr(6'h00, 32'h0F01);
    axi_read(6'h1C, d);
    n_cmp++;
    if (d !== 32'h0000_0510 || d !== m_reg[7]) begin
      n_bad++;
      $display("FAIL wstrb_readback: got %h, required 00000510", d);
    end
    axi_read(6'h38, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_bad++;
      $display("FAIL unmapped_read: got %h, required 0", d);
    end
    wait_frames(2);
    check_frame("edge_widths");
  endtask

  task automatic test_random();
    int p;
    for (int it = 0; it < 2; it++) begin
      p = $urandom_range(10, 20);
      wr(6'h04, 32'(p));
      for (int k = 0; k < N_CH; k++) wr(6'(16 + 4 * k), 32'($urandom_range(0, p + 3)));
      wr(6'h00, 32'h1 | (32'($urandom_range(0, 15)) << 8));
      wait_frames(2);
      check_frame("random");
    end
  endtask

  task automatic test_axi_stress();
    logic [31:0] v;
    int n;
    v = 32'($urandom_range(1, 16'hFFFF));
    @(posedge clk); #1;
    awaddr = 6'h14; awvalid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if (awready !== 1'b0 || wready !== 1'b0) begin
        n_bad++;
        $display("FAIL lone_aw: awready=%b wready=%b, required 0 0", awready, wready);
      end
    end
    @(posedge clk); #1;
    wdata = v; wstrb = 4'hF; wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (awready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    n_cmp++;
    if (awready !== 1'b1 || wready !== 1'b1) begin
      n_bad++;
      $display("FAIL aw_w_ready: awready=%b wready=%b, required 1 1", awready, wready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin
        n_bad++;
        $display("FAIL bvalid_hold: bvalid=%b bresp=%0d, required 1 0", bvalid, bresp);
      end
    end
    @(posedge clk); #1 bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL bvalid_clear: got %b, required 0", bvalid);
    end
    model_write(5, v, 4'hF);
    @(posedge clk); #1;
    araddr = 6'h14; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (arready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (rvalid !== 1'b1 || rdata !== m_reg[5] || rresp !== 2'b00) begin
        n_bad++;
        $display("FAIL rvalid_hold: rvalid=%b rdata=%h rresp=%0d, required 1 %h 0", rvalid, rdata, rresp, m_reg[5]);
      end
    end
    @(posedge clk); #1 rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL rvalid_clear: got %b, required 0", rvalid);
    end
  endtask

`ifdef SERVO_RAMP_EN
  task automatic test_ramp();
    int from, to, step, cur;
    wr(6'h0C, 32'd0);
    wr(6'h04, 32'd30);
    from = $urandom_range(2, 8);
    wr(6'h10, 32'(from));
    wr(6'h00, 32'h101);
    wait_frames(2);
    check_frame("ramp_start");
    step = $urandom_range(3, 6);
    to   = $urandom_range(20, 28);
    wr(6'h0C, 32'(step));
    wr(6'h10, 32'(to));
    wait_frames(1);
    cur = from;
    for (int f = 0; f < 4; f++) begin
      cur = ramp_next(cur, to, step);
      wait_frames(1);
      n_cmp++;
      if (last_hi[0] !== cur * DIV) begin
        n_bad++;
        $display("FAIL ramp frame %0d: got %0d, required %0d", f, last_hi[0], cur * DIV);
      end
    end
    wr(6'h0C, 32'd0);
  endtask
`endif

  task automatic test_disable();
    logic [31:0] d;
    int n, fc;
    wr(6'h10, 32'd500);
    wr(6'h18, 32'd500);
    wr(6'h00, 32'h0501);
    wait_frames(2);
    n_cmp++;
    if (servo_out !== 4'b0101) begin
      n_bad++;
      $display("FAIL both_high: got %b, required 0101", servo_out);
    end
    wr(6'h00, 32'h0401);
    n_cmp++;
    if (servo_out !== 4'b0100) begin
      n_bad++;
      $display("FAIL ch_disable: got %b, required 0100", servo_out);
    end
    wr(6'h00, 32'h0);
    n_cmp++;
    if (servo_out !== 4'b0000 || frame_start !== 1'b0) begin
      n_bad++;
      $display("FAIL gen_disable: servo=%b frame_start=%b, required 0000 0", servo_out, frame_start);
    end
    axi_read(6'h08, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_bad++;
      $display("FAIL status_stopped: got %h, required 0", d);
    end
    fc = frame_cnt;
    repeat (3 * DIV) @(negedge clk);
    n_cmp++;
    if (frame_cnt !== fc) begin
      n_bad++;
      $display("FAIL stopped_frames: got %0d, required %0d", frame_cnt, fc);
    end
    wr(6'h00, 32'h101);
    n = 0;
    while (frame_start !== 1'b1 && n < 3 * DIV) begin @(negedge clk); n++; end
    n_cmp++;
    if (n < DIV - 5 || n > DIV + 5) begin
      n_bad++;
      $display("FAIL reenable_boundary: got %0d cycles, required about %0d", n, DIV);
    end
  endtask

  initial begin
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    test_reset();
    test_basic();
    test_midframe();
    test_edge_widths();
    test_random();
    test_axi_stress();
`ifdef SERVO_RAMP_EN
    test_ramp();
`endif
    test_disable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
